// File: rtl/apa_pkg.sv
// Shared constants and types for the APA filter sequencer and the APA_Filter datapath.
// FILT_LAT lives here so the controller and the filter always agree on the result latency.
package apa_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_FILT_LAT = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_IN,
    ST_ISSUE,
    ST_WAIT_FILT,
    ST_OUTPUT,
    ST_DONE
  } apa_ctrl_state_t;

endpackage

// File: rtl/apa_filter_ctrl.sv
// Sequencer in front of APA_Filter: takes (noisy, desired) pairs, strobes the filter,
// waits its fixed latency, and returns filtered sample and weight over valid/ready.
module apa_filter_ctrl
#(
  parameter int DATA_W   = apa_pkg::DEF_DATA_W,
  parameter int CNT_W    = apa_pkg::DEF_CNT_W,
  parameter int FILT_LAT = apa_pkg::DEF_FILT_LAT
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  block_len,
  input  logic [CNT_W-1:0]  train_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_noisy,
  input  logic [DATA_W-1:0] in_desired,
  output logic [DATA_W-1:0] flt_noisy,
  output logic [DATA_W-1:0] flt_desired,
  output logic              flt_strobe,
  output logic              flt_adapt,
  input  logic [DATA_W-1:0] flt_out,
  input  logic [DATA_W-1:0] flt_weight,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_filtered,
  output logic [DATA_W-1:0] out_weight,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sample_cnt
);

  import apa_pkg::*;

  localparam int LAT_W = (FILT_LAT < 2) ? 1 : $clog2(FILT_LAT + 1);

  apa_ctrl_state_t  state;
  logic [CNT_W-1:0] block_lat;
  logic [CNT_W-1:0] train_lat;
  logic [LAT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = sample_cnt + CNT_W'(1);

  // Every output is a register updated alongside the state, so nothing combinational
  // reaches the ports. A zero-length block enters DONE with done still low and raises
  // it there, so its pulse lands two cycles after start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      block_lat    <= '0;
      train_lat    <= '0;
      lat_cnt      <= '0;
      in_ready     <= 1'b0;
      flt_noisy    <= '0;
      flt_desired  <= '0;
      flt_strobe   <= 1'b0;
      flt_adapt    <= 1'b0;
      out_valid    <= 1'b0;
      out_filtered <= '0;
      out_weight   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sample_cnt   <= '0;
    end else if (abort) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b0;
      flt_strobe <= 1'b0;
      flt_adapt  <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            block_lat  <= block_len;
            train_lat  <= train_len;
            sample_cnt <= '0;
            busy       <= 1'b1;
            if (block_len == '0) begin
              state <= ST_DONE;
            end else begin
              state    <= ST_WAIT_IN;
              in_ready <= 1'b1;
            end
          end
        end

        ST_WAIT_IN: begin
          if (in_valid && in_ready) begin
            flt_noisy   <= in_noisy;
            flt_desired <= in_desired;
            in_ready    <= 1'b0;
            flt_strobe  <= 1'b1;
            flt_adapt   <= (sample_cnt < train_lat);
            state       <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          flt_strobe <= 1'b0;
          flt_adapt  <= 1'b0;
          lat_cnt    <= LAT_W'(FILT_LAT);
          state      <= ST_WAIT_FILT;
        end

        // The cycle in which the counter steps from 1 to 0 is the one where the
        // filter result is valid, FILT_LAT cycles after the strobe.
        ST_WAIT_FILT: begin
          lat_cnt <= lat_cnt - LAT_W'(1);
          if (lat_cnt == LAT_W'(1)) begin
            out_filtered <= flt_out;
            out_weight   <= flt_weight;
            out_valid    <= 1'b1;
            state        <= ST_OUTPUT;
          end
        end

        ST_OUTPUT: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            sample_cnt <= cnt_inc;
            if (cnt_inc == block_lat) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state    <= ST_WAIT_IN;
              in_ready <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            done <= 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
